// File: rtl/reg_file_sb.sv
// reg_file_sb: 32 x 32-bit integer register file with write-through bypass
// and a per-register pending-writer scoreboard.
//
// Ports
//   clk, rst        core clock; asynchronous active-high reset
//   write_back_out  write-back bundle {Wdata, rd, Wreg}; commits at the edge
//   rs1, rs2        combinational read addresses
//   rdata1, rdata2  read data (x0 reads 0, same-cycle write is bypassed)
//   issue_valid     decode issues an instruction this cycle
//   issue_rd        destination of the issued instruction
//   issue_Wreg      the issued instruction writes issue_rd
//   squash_valid    an in-flight writer is cancelled this cycle
//   squash_rd       destination of the cancelled writer
//   busy1, busy2    source operand still waits on an outstanding writer
//   sb_err          sticky scoreboard under/overflow flag, cleared by rst
//
// There is no valid/ready handshake here: every input is sampled
// unconditionally each cycle and the block never back-pressures.

package reg_file_sb_pkg;
  typedef struct packed {
    logic [31:0] Wdata;
    logic [4:0]  rd;
    logic        Wreg;
  } write_back_out_t;
endpackage

module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  write_back_out_t write_back_out,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [31:0]     rdata1,
  output logic [31:0]     rdata2,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            issue_Wreg,
  input  logic            squash_valid,
  input  logic [4:0]      squash_rd,
  output logic            busy1,
  output logic            busy2,
  output logic            sb_err
);

  // Two extra bits give room for the -2..+1 net change without wrapping,
  // so under/overflow can be detected with a plain signed compare.
  localparam int CW = PEND_W + 2;
  localparam logic signed [CW-1:0] PEND_MAX_S = $signed({2'b00, {PEND_W{1'b1}}});

  logic [31:0]       regs_q [32];
  logic [PEND_W-1:0] pend_q [32];
  logic [PEND_W-1:0] pend_d [32];
  logic              sb_err_q;
  logic              sb_err_d;

  logic              wr_en;
  logic              ev_inc;
  logic              ev_decw;
  logic              ev_decs;
  logic signed [CW-1:0] nxt;
  logic              decw1;
  logic              decw2;

  assign wr_en = write_back_out.Wreg && (write_back_out.rd != 5'd0);

  // ---------------------------------------------------------------------
  // Register array. Entry 0 is held at zero and never written.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en) begin
      regs_q[write_back_out.rd] <= write_back_out.Wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Read ports: x0 first, then bypass of the in-flight write, then array.
  // ---------------------------------------------------------------------
  always_comb begin
    rdata1 = regs_q[rs1];
    if (rs1 == 5'd0) begin
      rdata1 = '0;
    end else if (wr_en && (write_back_out.rd == rs1)) begin
      rdata1 = write_back_out.Wdata;
    end
  end

  always_comb begin
    rdata2 = regs_q[rs2];
    if (rs2 == 5'd0) begin
      rdata2 = '0;
    end else if (wr_en && (write_back_out.rd == rs2)) begin
      rdata2 = write_back_out.Wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Scoreboard next state. Counter 0 exists only to keep indexing simple;
  // it is pinned to zero so x0 is never busy.
  // ---------------------------------------------------------------------
  always_comb begin
    pend_d   = pend_q;
    sb_err_d = sb_err_q;
    ev_inc   = 1'b0;
    ev_decw  = 1'b0;
    ev_decs  = 1'b0;
    nxt      = '0;
    pend_d[0] = '0;
    for (int r = 1; r < 32; r++) begin
      ev_inc  = issue_valid && issue_Wreg && (issue_rd == 5'(r));
      ev_decw = write_back_out.Wreg && (write_back_out.rd == 5'(r));
      ev_decs = squash_valid && (squash_rd == 5'(r));
      nxt = $signed({2'b00, pend_q[r]})
          + $signed(CW'(ev_inc))
          - $signed(CW'(ev_decw))
          - $signed(CW'(ev_decs));
      if (nxt < 0) begin
        pend_d[r] = '0;
        sb_err_d  = 1'b1;
      end else if (nxt > PEND_MAX_S) begin
        pend_d[r] = {PEND_W{1'b1}};
        sb_err_d  = 1'b1;
      end else begin
        pend_d[r] = nxt[PEND_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        pend_q[r] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      sb_err_q <= sb_err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Busy: a writeback completing this cycle is satisfied by the bypass, so
  // it is subtracted here. Issue and squash only act from the next cycle.
  // ---------------------------------------------------------------------
  assign decw1 = write_back_out.Wreg && (write_back_out.rd == rs1);
  assign decw2 = write_back_out.Wreg && (write_back_out.rd == rs2);

  assign busy1 = (rs1 != 5'd0) && ((pend_q[rs1] - PEND_W'(decw1)) != '0);
  assign busy2 = (rs2 != 5'd0) && ((pend_q[rs2] - PEND_W'(decw2)) != '0);

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed testbench for reg_file_sb. Inputs are driven 1 time unit after
// the rising edge and outputs are sampled 1 time unit after that, well
// before the next rising edge.

module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT signals
  write_back_out_t wb;
  logic [4:0]  rs1, rs2, issue_rd, squash_rd;
  logic        issue_valid, issue_Wreg, squash_valid;
  logic [31:0] rdata1, rdata2;
  logic        busy1, busy2, sb_err;

  int n_vec = 0;
  int n_err = 0;

  reg_file_sb #(.PEND_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .write_back_out (wb),
    .rs1            (rs1),
    .rs2            (rs2),
    .rdata1         (rdata1),
    .rdata2         (rdata2),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_Wreg     (issue_Wreg),
    .squash_valid   (squash_valid),
    .squash_rd      (squash_rd),
    .busy1          (busy1),
    .busy2          (busy2),
    .sb_err         (sb_err)
  );

  // driver tasks
  task automatic clear_inputs();
    wb           = '0;
    rs1          = 5'd0;
    rs2          = 5'd0;
    issue_valid  = 1'b0;
    issue_rd     = 5'd0;
    issue_Wreg   = 1'b0;
    squash_valid = 1'b0;
    squash_rd    = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_Wreg  = 1'b1;
    issue_rd    = rd;
  endtask

  task automatic do_write(input logic [4:0] rd, input logic [31:0] data);
    wb.Wreg  = 1'b1;
    wb.rd    = rd;
    wb.Wdata = data;
  endtask

  task automatic do_squash(input logic [4:0] rd);
    squash_valid = 1'b1;
    squash_rd    = rd;
  endtask

  // checker
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;

    // reset state
    rs1 = 5'd5; rs2 = 5'd5;
    settle();
    check_eq("rst_rdata1", rdata1, 32'h0);
    check_eq("rst_rdata2", rdata2, 32'h0);
    check_eq("rst_busy1", {31'b0, busy1}, 32'h0);
    check_eq("rst_busy2", {31'b0, busy2}, 32'h0);
    check_eq("rst_sb_err", {31'b0, sb_err}, 32'h0);
    rst = 1'b0;
    tick();

    // write x5 without an issued writer (underflow), then reset mid-run
    do_write(5'd5, 32'h1234);
    tick();
    rs1 = 5'd5;
    settle();
    check_eq("x5_written", rdata1, 32'h1234);
    check_eq("x5_underflow_err", {31'b0, sb_err}, 32'h1);
    rst = 1'b1;
    settle();
    check_eq("midrst_rdata1", rdata1, 32'h0);
    check_eq("midrst_busy1", {31'b0, busy1}, 32'h0);
    check_eq("midrst_sb_err", {31'b0, sb_err}, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // write/read and x0
    do_issue(5'd7);
    tick();
    do_write(5'd7, 32'hDEADBEEF);
    tick();
    rs1 = 5'd7;
    do_write(5'd0, 32'hFFFFFFFF);
    rs2 = 5'd0;
    settle();
    check_eq("x7_read", rdata1, 32'hDEADBEEF);
    check_eq("x0_bypass", rdata2, 32'h0);
    tick();
    rs2 = 5'd0;
    settle();
    check_eq("x0_read", rdata2, 32'h0);
    check_eq("x0_no_err", {31'b0, sb_err}, 32'h0);

    // bypass
    do_issue(5'd9);
    tick();
    do_write(5'd9, 32'hA5A5A5A5);
    rs1 = 5'd9; rs2 = 5'd9;
    settle();
    check_eq("byp_rdata1", rdata1, 32'hA5A5A5A5);
    check_eq("byp_rdata2", rdata2, 32'hA5A5A5A5);
    check_eq("byp_busy1", {31'b0, busy1}, 32'h0);
    tick();
    wb.Wreg = 1'b0; wb.rd = 5'd9; wb.Wdata = 32'h12345678;
    rs1 = 5'd9;
    settle();
    check_eq("nobyp_rdata1", rdata1, 32'hA5A5A5A5);

    // scoreboard basic
    do_issue(5'd3);
    rs1 = 5'd3;
    settle();
    check_eq("sb3_issue_cycle", {31'b0, busy1}, 32'h0);
    tick();
    rs1 = 5'd3;
    settle();
    check_eq("sb3_busy", {31'b0, busy1}, 32'h1);
    do_write(5'd3, 32'h33);
    settle();
    check_eq("sb3_wb_busy", {31'b0, busy1}, 32'h0);
    check_eq("sb3_wb_data", rdata1, 32'h33);
    tick();
    rs1 = 5'd3;
    settle();
    check_eq("sb3_after", {31'b0, busy1}, 32'h0);

    // multiple in-flight and squash on x4
    do_issue(5'd4);
    tick();
    do_issue(5'd4);
    tick();
    rs1 = 5'd4; rs2 = 5'd4;
    do_write(5'd4, 32'h44);
    settle();
    check_eq("sb4_wb1_busy1", {31'b0, busy1}, 32'h1);
    check_eq("sb4_wb1_busy2", {31'b0, busy2}, 32'h1);
    tick();
    do_issue(5'd4);
    do_squash(5'd4);
    rs1 = 5'd4;
    settle();
    check_eq("sb4_iss_sq_busy", {31'b0, busy1}, 32'h1);
    tick();
    rs1 = 5'd4;
    settle();
    check_eq("sb4_pend1_busy", {31'b0, busy1}, 32'h1);
    do_write(5'd4, 32'h45);
    settle();
    check_eq("sb4_wb2_busy", {31'b0, busy1}, 32'h0);
    tick();
    rs1 = 5'd4;
    settle();
    check_eq("sb4_pend0_busy", {31'b0, busy1}, 32'h0);
    do_issue(5'd4);
    tick();
    do_issue(5'd4);
    tick();
    do_issue(5'd4);
    do_write(5'd4, 32'h46);
    do_squash(5'd4);
    rs1 = 5'd4;
    settle();
    check_eq("sb4_triple_busy", {31'b0, busy1}, 32'h1);
    tick();
    rs1 = 5'd4;
    settle();
    check_eq("sb4_after_triple", {31'b0, busy1}, 32'h1);
    do_write(5'd4, 32'h47);
    settle();
    check_eq("sb4_last_wb", {31'b0, busy1}, 32'h0);
    tick();
    rs1 = 5'd4;
    settle();
    check_eq("sb4_drained", {31'b0, busy1}, 32'h0);
    check_eq("sb4_no_err", {31'b0, sb_err}, 32'h0);

    // underflow error on x6
    do_write(5'd6, 32'h66);
    settle();
    check_eq("uf_err_same_cycle", {31'b0, sb_err}, 32'h0);
    tick();
    rs1 = 5'd6;
    settle();
    check_eq("uf_err_set", {31'b0, sb_err}, 32'h1);
    check_eq("uf_pend_held0", {31'b0, busy1}, 32'h0);
    check_eq("uf_data", rdata1, 32'h66);
    tick();
    tick();
    check_eq("uf_err_sticky", {31'b0, sb_err}, 32'h1);

    // clear with reset, then overflow on x8
    rst = 1'b1;
    settle();
    check_eq("err_cleared", {31'b0, sb_err}, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_issue(5'd8);
      tick();
    end
    check_eq("of_pend3_no_err", {31'b0, sb_err}, 32'h0);
    do_issue(5'd8);
    tick();
    check_eq("of_err_set", {31'b0, sb_err}, 32'h1);
    rs1 = 5'd8;
    do_write(5'd8, 32'h81);
    settle();
    check_eq("of_wb1_busy", {31'b0, busy1}, 32'h1);
    tick();
    rs1 = 5'd8;
    do_write(5'd8, 32'h82);
    settle();
    check_eq("of_wb2_busy", {31'b0, busy1}, 32'h1);
    tick();
    rs1 = 5'd8;
    do_write(5'd8, 32'h83);
    settle();
    check_eq("of_wb3_busy", {31'b0, busy1}, 32'h0);
    check_eq("of_wb3_data", rdata1, 32'h83);
    tick();
    check_eq("of_err_sticky", {31'b0, sb_err}, 32'h1);
    rst = 1'b1;
    settle();
    check_eq("of_err_rst", {31'b0, sb_err}, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Integer register file for the pipelined core, with a pending-write scoreboard. It is the receiving end of the write-back bundle: it consumes `write_back_out_t` (Wdata, rd, Wreg) from `write_back`, commits the data, and serves two combinational read ports to decode. Same-cycle write-through bypass is included. The scoreboard counts in-flight writers per register and flags hazards on the source operands.

## Interface

Parameters:
- `PEND_W`, default 2: width of each per-register pending counter. Maximum in-flight writers per register is 2^PEND_W-1.

Ports:
- `clk`  input  1  core clock; all state updates on the rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `write_back_out`  input  `write_back_out_t`  write-back bundle: `Wdata[31:0]`, `rd[4:0]`, `Wreg`.
- `rs1`  input  5  read address, port 1.
- `rs2`  input  5  read address, port 2.
- `rdata1`  output  32  read data, port 1.
- `rdata2`  output  32  read data, port 2.
- `issue_valid`  input  1  decode issues an instruction this cycle.
- `issue_rd`  input  5  destination register of the issued instruction.
- `issue_Wreg`  input  1  the issued instruction writes `issue_rd`.
- `squash_valid`  input  1  an in-flight writer is cancelled this cycle.
- `squash_rd`  input  5  destination register of the cancelled writer.
- `busy1`  output  1  `rs1` has an outstanding writer whose data is not available this cycle.
- `busy2`  output  1  `rs2` has an outstanding writer whose data is not available this cycle.
- `sb_err`  output  1  sticky scoreboard protocol error flag.

## Operation

**Storage**
- 32 x 32-bit registers.
- x0 reads 0 always. Writes to x0 are discarded.

**Write**
- Condition: `write_back_out.Wreg`=1 and `write_back_out.rd`!=0.
- Effect: `regs[rd] <= Wdata` at the clock edge.

**Read** (combinational)
- rdata1 = 0 when rs1==0.
- Else rdata1 = Wdata when a write is active this cycle and rd==rs1 (bypass).
- Else rdata1 = regs[rs1].
- rdata2 follows the same rule with rs2.

**Scoreboard**
- Each register r≠0 has a counter `pend[r]` of width PEND_W. x0 has no counter and is never busy.
- inc(r) = issue_valid & issue_Wreg & issue_rd==r.
- decW(r) = Wreg & rd==r.
- decS(r) = squash_valid & squash_rd==r.
- Next value: pend[r] + inc − decW − decS. All three events may occur in the same cycle; a net change of −2..+1 is legal.
- Underflow: if the result would be <0, pend holds at 0 and sb_err is set.
- Overflow: if the result would exceed 2^PEND_W−1, pend holds at max and sb_err is set.
- busy1 = (rs1≠0) & ((pend[rs1] − decW(rs1)) ≠ 0). A writer completing this cycle is covered by the bypass. Squash does not clear busy in the same cycle.
- busy2 is defined the same way for rs2.
- Issue in cycle N to register r does not affect busy in cycle N. busy reflects the new value from cycle N+1.
- sb_err is sticky and is cleared only by rst.

## Timing

**Reset**
- All 32 registers = 0.
- All pend = 0.
- sb_err = 0.
- Consequently rdata1/rdata2 = 0 and busy1/busy2 = 0 during reset and immediately after it.
- Reset asserted mid-operation clears state immediately. Writes, issues and squashes in that cycle are lost.

**Latency**
- Read: 0 cycles (combinational).
- Write: data visible through the bypass in the same cycle, and through the array from the next cycle.
- Scoreboard: 1 cycle from issue/squash to the updated busy. Writeback clears busy in the same cycle.

**Simultaneous events**
- Write and read to the same register in one cycle: the new data is returned.
- Issue and writeback to the same register in one cycle: pend is unchanged (+1−1), and busy stays asserted if pend was ≥2.

## Test plan

- **Reset:** assert rst mid-run after writing x5=0x1234. Required: rdata1(rs1=5)=0, busy1=0, sb_err=0.
- **Write/read and x0:** write x7=0xDEADBEEF; next cycle rs1=7 → 0xDEADBEEF. Write x0=0xFFFFFFFF; rs2=0 → 0.
- **Bypass:** in the same cycle, Wreg=1, rd=9, Wdata=0xA5A5A5A5, rs1=rs2=9. Required: rdata1=rdata2=0xA5A5A5A5. With Wreg=0, the old x9 value is returned.
- **Scoreboard basic:** issue rd=3. Next cycle rs1=3 → busy1=1. Writeback rd=3 → busy1=0 in that same cycle with rdata1=Wdata. Following cycle pend[3]=0.
- **Multiple in-flight and squash:**
  - Issue rd=4 twice, so pend=2. First writeback → busy1=1.
  - Issue again and squash rd=4 in the same cycle → pend stays 1.
  - Writeback → pend=0.
  - Simultaneous issue+writeback+squash on x4 with pend=2 → pend=1.
- **Errors:**
  - Writeback rd=6 with pend[6]=0 → pend stays 0, sb_err=1 from next cycle and remains set.
  - Issue x8 four times with PEND_W=2 → pend=3, sb_err=1.
  - Only rst clears sb_err.
